// File: rtl/overlay_accum_drain.sv
// Drain stage behind the 27x27 MAC overlay: tracks result validity through a delay pipe,
// accumulates S_reg per SIMD lane over a group, and queues group results behind valid/ready.
module overlay_accum_drain #(
  parameter int ACC_W      = 54,
  parameter int LEN_W      = 8,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic             issue_last,
  input  logic [1:0]       issue_mode,
  output logic             issue_ready,
  input  logic [ACC_W-1:0] s_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [LEN_W-1:0] out_count,
  output logic [1:0]       out_mode
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int W2 = ACC_W / 2;
  localparam int W3 = ACC_W / 3;
  localparam int W6 = ACC_W / 6;
  localparam logic [LEN_W-1:0] CNT_MAX = '1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

  logic accept;
  logic push;
  logic pop;

  // ---------------- delay pipe ----------------
  logic [LATENCY-1:0] pipe_valid;
  logic [LATENCY-1:0] pipe_last;
  logic [1:0]         pipe_mode [LATENCY];
  logic               beat_valid;
  logic               beat_last;
  logic [1:0]         beat_mode;

  assign accept = issue_valid && issue_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_mode[i] <= 2'b00;
    end else begin
      pipe_valid[0] <= accept;
      pipe_last[0]  <= accept && issue_last;
      pipe_mode[0]  <= issue_mode;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_last[i]  <= pipe_last[i-1];
        pipe_mode[i]  <= pipe_mode[i-1];
      end
    end
  end

  assign beat_valid = pipe_valid[LATENCY-1];
  assign beat_last  = pipe_last[LATENCY-1];
  assign beat_mode  = pipe_mode[LATENCY-1];

  // ---------------- lane-wise accumulator ----------------
  function automatic logic [ACC_W-1:0] lane_add(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b,
                                                input logic [1:0]       m);
    logic [ACC_W-1:0] r;
    r = '0;
    case (m)
      2'b00: r = a + b;
      2'b01: for (int i = 0; i < 2; i++) r[i*W2 +: W2] = a[i*W2 +: W2] + b[i*W2 +: W2];
      2'b10: for (int i = 0; i < 3; i++) r[i*W3 +: W3] = a[i*W3 +: W3] + b[i*W3 +: W3];
      default: for (int i = 0; i < 6; i++) r[i*W6 +: W6] = a[i*W6 +: W6] + b[i*W6 +: W6];
    endcase
    return r;
  endfunction

  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] grp_count;
  logic [1:0]       grp_mode;
  logic             grp_open;
  logic [ACC_W-1:0] acc_next;
  logic [LEN_W-1:0] count_next;
  logic [1:0]       mode_next;

  always_comb begin
    acc_next   = s_in;
    count_next = LEN_W'(1);
    mode_next  = beat_mode;
    if (grp_open) begin
      acc_next   = lane_add(acc, s_in, grp_mode);
      count_next = (grp_count == CNT_MAX) ? grp_count : grp_count + LEN_W'(1);
      mode_next  = grp_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      grp_count <= '0;
      grp_mode  <= 2'b00;
      grp_open  <= 1'b0;
    end else if (beat_valid) begin
      acc       <= acc_next;
      grp_count <= count_next;
      grp_mode  <= mode_next;
      grp_open  <= !beat_last;
    end
  end

  // ---------------- result FIFO ----------------
  logic [ACC_W-1:0] mem_data  [FIFO_DEPTH];
  logic [LEN_W-1:0] mem_count [FIFO_DEPTH];
  logic [1:0]       mem_mode  [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    inflight;
  logic [CW:0]      credit_sum;

  assign push = beat_valid && beat_last;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]  <= acc_next;
      mem_count[wr_ptr] <= count_next;
      mem_mode[wr_ptr]  <= mode_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      // a last beat leaving the pipe moves its credit from inflight into fifo_count
      case ({accept && issue_last, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign credit_sum  = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue_ready = credit_sum < DEPTH_V;

  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? mem_data[rd_ptr]  : '0;
  assign out_count = out_valid ? mem_count[rd_ptr] : '0;
  assign out_mode  = out_valid ? mem_mode[rd_ptr]  : 2'b00;

endmodule

// File: tb/tb_overlay_accum_drain.sv
// Directed bench for overlay_accum_drain; a small delay-line stub stands in for the overlay's S_reg.
module tb_overlay_accum_drain;

  localparam int ACC_W   = 54;
  localparam int LEN_W   = 8;
  localparam int LATENCY = 3;
  localparam logic [ACC_W-1:0] JUNK = 54'h2A_5A5A_5A5A_5A5A;

  logic             clk;
  logic             reset;
  logic             issue_valid;
  logic             issue_last;
  logic [1:0]       issue_mode;
  logic             issue_ready;
  logic [ACC_W-1:0] s_in;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [LEN_W-1:0] out_count;
  logic [1:0]       out_mode;

  logic [ACC_W-1:0] issue_s;
  logic [ACC_W-1:0] sd [LATENCY];

  int n_vec = 0;
  int n_err = 0;

  overlay_accum_drain #(
    .ACC_W(ACC_W), .LEN_W(LEN_W), .LATENCY(LATENCY), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_last(issue_last), .issue_mode(issue_mode),
    .issue_ready(issue_ready), .s_in(s_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_mode(out_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // overlay stand-in: whatever operands were presented reappear LATENCY cycles later
  always @(posedge clk) begin
    sd[0] <= issue_valid ? issue_s : JUNK;
    for (int i = 1; i < LATENCY; i++) sd[i] <= sd[i-1];
  end
  assign s_in = sd[LATENCY-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic last, input logic [1:0] mode, input logic [ACC_W-1:0] val);
    issue_valid = 1'b1;
    issue_last  = last;
    issue_mode  = mode;
    issue_s     = val;
    tick();
    issue_valid = 1'b0;
    issue_last  = 1'b0;
  endtask

  task automatic wait_valid(input int exp_ticks, input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, 64'(n), 64'(exp_ticks));
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_last = 1'b0; issue_mode = 2'b00;
    issue_s = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_mode", out_mode, 0);
    check("rst_issue_ready", issue_ready, 1);

    // mode 00: 10+20+30
    beat(1'b0, 2'b00, 54'd10);
    beat(1'b0, 2'b00, 54'd20);
    beat(1'b1, 2'b00, 54'd30);
    wait_valid(3, "m00_latency");
    check("m00_data", out_data, 64'd60);
    check("m00_count", out_count, 3);
    check("m00_mode", out_mode, 0);
    pop_one();
    check("m00_popped", out_valid, 0);

    // mode 01: lane0 wraps without carrying into lane1
    beat(1'b0, 2'b01, {27'd1, 27'h7FFFFFF});
    beat(1'b1, 2'b01, {27'd2, 27'd1});
    wait_valid(3, "m01_latency");
    check("m01_data", out_data, {27'd3, 27'd0});
    check("m01_count", out_count, 2);
    check("m01_mode", out_mode, 1);
    pop_one();

    // mode 11: each 9-bit lane 1FF+1 wraps to 0
    beat(1'b0, 2'b11, {6{9'h1FF}});
    beat(1'b1, 2'b11, {6{9'h001}});
    wait_valid(3, "m11_latency");
    check("m11_data", out_data, 0);
    check("m11_mode", out_mode, 3);
    pop_one();

    // mode 10: 5+A per 18-bit lane
    beat(1'b0, 2'b10, {3{18'h00005}});
    beat(1'b1, 2'b10, {3{18'h0000A}});
    wait_valid(3, "m10_latency");
    check("m10_data", out_data, {3{18'h0000F}});
    check("m10_mode", out_mode, 2);
    pop_one();

    // mode change mid-group is ignored: latched 3x18 lanes still wrap independently
    beat(1'b0, 2'b10, {3{18'h3FFFF}});
    beat(1'b1, 2'b00, {3{18'h00001}});
    wait_valid(3, "mix_latency");
    check("mix_data", out_data, 0);
    check("mix_mode", out_mode, 2);
    check("mix_count", out_count, 2);
    pop_one();

    // 260-beat group: count saturates at 255, data keeps accumulating
    for (int i = 0; i < 259; i++) beat(1'b0, 2'b00, 54'd1);
    beat(1'b1, 2'b00, 54'd1);
    wait_valid(3, "sat_latency");
    check("sat_data", out_data, 64'd260);
    check("sat_count", out_count, 255);
    pop_one();

    // back-pressure: four single-beat groups fill every credit
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("bp_ready_%0d", k), issue_ready, 1);
      beat(1'b1, 2'b00, ACC_W'(k));
    end
    check("bp_ready_full", issue_ready, 0);
    issue_valid = 1'b1; issue_last = 1'b1; issue_mode = 2'b00; issue_s = 54'd5;
    repeat (5) tick();
    check("bp_stall", issue_ready, 0);
    check("bp_head_valid", out_valid, 1);
    check("bp_data1", out_data, 1);
    out_ready = 1'b1;
    tick();
    check("bp_data2", out_data, 2);
    check("bp_ready_after_pop", issue_ready, 1);
    tick();
    issue_valid = 1'b0; issue_last = 1'b0;
    check("bp_data3", out_data, 3);
    tick();
    check("bp_data4", out_data, 4);
    check("bp_count4", out_count, 1);
    tick();
    check("bp_drained", out_valid, 0);
    wait_valid(1, "bp_fifth_latency");
    check("bp_data5", out_data, 5);
    tick();
    check("bp_empty", out_valid, 0);

    // back-to-back single-beat groups with a live consumer
    beat(1'b1, 2'b00, 54'd7);
    beat(1'b1, 2'b00, 54'd8);
    beat(1'b1, 2'b00, 54'd9);
    wait_valid(1, "b2b_latency");
    check("b2b_data7", out_data, 7);
    check("b2b_count7", out_count, 1);
    tick();
    check("b2b_data8", out_data, 8);
    tick();
    check("b2b_data9", out_data, 9);
    check("b2b_count9", out_count, 1);
    tick();
    check("b2b_empty", out_valid, 0);
    out_ready = 1'b0;

    // reset after the first beat of a group has been accumulated
    beat(1'b0, 2'b00, 54'd5);
    beat(1'b0, 2'b00, 54'd5);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_issue_ready", issue_ready, 1);
    check("mrst_out_data", out_data, 0);
    beat(1'b1, 2'b00, 54'd4);
    wait_valid(3, "mrst_latency");
    check("mrst_data", out_data, 4);
    check("mrst_count", out_count, 1);
    pop_one();
    check("mrst_empty", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/overlay_accum_drain.md
Name: overlay_accum_drain

Overview:
- Downstream drain/accumulation stage for the C3x3_F1 27x27 MAC overlay.
- Tracks which overlay issue cycles produce valid S_reg results, using an internal delay pipe of LATENCY cycles.
- Accumulates S_reg lane-wise per SIMD mode across a group of beats and queues finished group results in a small FIFO behind a valid/ready output.
- Generates issue_ready back-pressure for the operand feeder. The parent ties the overlay's result_2 and CIN to zero.

Parameters:
- ACC_W, 54, width of overlay S_reg and of the accumulator.
- LEN_W, 8, width of the per-group beat counter.
- LATENCY, 3, cycles from an accepted issue (a/b/mode presented) to the matching S_reg value on s_in; must be ≥1.
- FIFO_DEPTH, 4, number of output result entries (power of 2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- issue_valid  in  1  feeder presents a beat to the overlay this cycle.
- issue_last  in  1  the beat is the last of its group.
- issue_mode  in  2  SIMD mode of the beat (same value driven to overlay mode).
- issue_ready  out  1  beat accepted when issue_valid && issue_ready.
- s_in  in  ACC_W  overlay S_reg.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  ACC_W  accumulated group result.
- out_count  out  LEN_W  number of beats in the group (saturating).
- out_mode  out  2  mode of the group.

Behaviour:
- Reset (synchronous, active-high): clears the delay pipe, accumulator, beat counter, FIFO, and in-flight counter. Takes effect the cycle it is sampled, including mid-group; partial group contents are discarded. Output values after reset: out_valid=0, out_data=0, out_count=0, out_mode=0, issue_ready=1.
- Delay pipe: each accepted beat carries {valid, last, mode} through LATENCY registers. Its output (beat_valid, beat_last, beat_mode) is cycle-aligned with s_in. Beats not accepted enter the pipe as valid=0. s_in is ignored when beat_valid=0.
- Lane split by mode, with wrap modulo lane width and no carry crossing lane boundaries:
  - 00: 1x54.
  - 01: 2x27, lanes [26:0] and [53:27].
  - 10: 3x18.
  - 11: 6x9, lane0 at LSB.
- Accumulator:
  - First beat of a group (open flag clear): acc <= s_in, count <= 1, group mode latched from beat_mode.
  - Later beats: acc <= lane_add(acc, s_in) using the latched mode; count increments, saturating at 2^LEN_W-1.
  - A beat_mode differing from the latched mode mid-group is ignored; the latched mode governs.
- Group close: on beat_valid && beat_last, push {acc_next, count_next, mode} into the FIFO and clear the open flag in the same cycle. The next cycle may start a new group with no bubble.
- Latency: out_valid for a group rises at earliest 1 cycle after its last beat on s_in (registered FIFO, show-ahead head).
- Credit flow control:
  - inflight counts accepted last-beats still inside the pipe.
  - issue_ready = (fifo_count + inflight) < FIFO_DEPTH, computed from registered state.
  - Pipe emergence of a last beat decrements inflight and increments fifo_count in the same cycle, leaving the sum unchanged.
  - A pop frees one credit in the next cycle.
  - Result: a push never finds the FIFO full, and no result is ever dropped.
- Simultaneous push and pop: allowed at any occupancy; count unchanged.
- Ordering: FIFO output order equals group completion order.
- out_* hold stable while out_valid && !out_ready.

Test Plan:
- mode 00: issue 3 beats (last on 3rd), s_in = 10, 20, 30 at LATENCY -> one cycle after 3rd beat: out_valid=1, out_data=60, out_count=3, out_mode=0.
- mode 01 wrap: beats s_in = {lane1=1, lane0=27'h7FFFFFF}, then {lane1=2, lane0=1} -> out_data lane0=0, lane1=3 (no cross-lane carry).
- mode 11: two beats, each lane 9'h1FF then 9'h001 -> out_data=0; mode 10: 18'h00005 + 18'h0000A per lane -> each lane 18'h0000F.
- Back-pressure: out_ready=0, issue 4 single-beat groups (s_in 1..4) -> issue_ready=0 after the 4th accept, 5th beat stalls. Raise out_ready -> out_data 1, 2, 3, 4 in order, issue_ready=1 the cycle after the first pop.
- Back-to-back single-beat groups with issue_last every cycle, s_in 7, 8, 9 -> three results 7, 8, 9, each count=1, on consecutive cycles.
- Reset mid-group: after 2 beats of value 5, assert reset 1 cycle -> out_valid=0, issue_ready=1. Next group of 1 beat with s_in 4 -> out_data=4, out_count=1.
